// File: rtl/pc_update_unit_pkg.sv
// Shared constants for the program-counter unit: word width, pc_src encodings
// and the default reset PC.
package pc_update_unit_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] PC_SRC_SEQ = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;
  localparam logic [1:0] PC_SRC_REG = 2'd3;

  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic is_word_aligned(input logic [WORD_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_update_unit_pc_next_mux.sv
// Combinational next-PC candidate selection plus word-alignment check.
module pc_next_mux
  import pc_update_unit_pkg::*;
(
  input  logic [1:0]        pc_src,
  input  logic [WORD_W-1:0] pc,
  input  logic [WORD_W-1:0] branch_target,
  input  logic [25:0]       jump_index,
  input  logic [WORD_W-1:0] reg_target,
  output logic [WORD_W-1:0] candidate,
  output logic              aligned
);

  always_comb begin
    candidate = pc + 32'd4;
    unique case (pc_src)
      PC_SRC_SEQ: candidate = pc + 32'd4;
      PC_SRC_BR:  candidate = branch_target;
      PC_SRC_JMP: candidate = {pc[31:28], jump_index, 2'b00};
      PC_SRC_REG: candidate = reg_target;
      default:    candidate = pc + 32'd4;
    endcase
  end

  assign aligned = is_word_aligned(candidate);

endmodule

// File: rtl/pc_update_unit.sv
// Program counter, latched branch target and sticky misalignment trap.
// Optional branch statistics counters are compiled in with PC_BRANCH_STATS_EN.
module pc_update_unit
  import pc_update_unit_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_write,
  input  logic              pc_write_cond,
  input  logic              branch_ne,
  input  logic              alu_zero,
  input  logic [1:0]        pc_src,
  input  logic              bt_load,
  input  logic [WORD_W-1:0] offset_shifted,
  input  logic [25:0]       jump_index,
  input  logic [WORD_W-1:0] reg_target,
  input  logic              err_clr,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] branch_target,
  output logic              pc_updated,
  output logic              misalign_err
`ifdef PC_BRANCH_STATS_EN
  ,
  output logic [WORD_W-1:0] branch_count,
  output logic [WORD_W-1:0] taken_count
`endif
);

  logic [WORD_W-1:0] candidate;
  logic              aligned;
  logic              take;
  logic              do_write;
  logic              do_trap;

  pc_next_mux u_pc_next_mux (
    .pc_src        (pc_src),
    .pc            (pc),
    .branch_target (branch_target),
    .jump_index    (jump_index),
    .reg_target    (reg_target),
    .candidate     (candidate),
    .aligned       (aligned)
  );

  // pc_write dominates; the branch condition only matters for conditional writes
  assign take     = pc_write | (pc_write_cond & (alu_zero ^ branch_ne));
  assign do_write = take & aligned;
  assign do_trap  = take & ~aligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      branch_target <= '0;
      pc_updated    <= 1'b0;
      misalign_err  <= 1'b0;
    end else begin
      pc_updated <= do_write;
      if (do_write) begin
        pc <= candidate;
      end
      // Target is formed from the PC before any same-cycle write.
      if (bt_load) begin
        branch_target <= pc + offset_shifted;
      end
      if (do_trap) begin
        misalign_err <= 1'b1;
      end else if (err_clr) begin
        misalign_err <= 1'b0;
      end
    end
  end

`ifdef PC_BRANCH_STATS_EN
  logic cond_branch;
  assign cond_branch = pc_write_cond & ~pc_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count <= '0;
      taken_count  <= '0;
    end else begin
      if (cond_branch) begin
        branch_count <= branch_count + 32'd1;
      end
      if (cond_branch & do_write) begin
        taken_count <= taken_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_update_unit.sv
// Self-checking bench for pc_update_unit: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_pc_update_unit;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write, pc_write_cond, branch_ne, alu_zero, bt_load, err_clr;
  logic [1:0]  pc_src;
  logic [31:0] offset_shifted, reg_target;
  logic [25:0] jump_index;
  logic [31:0] pc, branch_target;
  logic        pc_updated, misalign_err;
`ifdef PC_BRANCH_STATS_EN
  logic [31:0] branch_count, taken_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_update_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_write       (pc_write),
    .pc_write_cond  (pc_write_cond),
    .branch_ne      (branch_ne),
    .alu_zero       (alu_zero),
    .pc_src         (pc_src),
    .bt_load        (bt_load),
    .offset_shifted (offset_shifted),
    .jump_index     (jump_index),
    .reg_target     (reg_target),
    .err_clr        (err_clr),
    .pc             (pc),
    .branch_target  (branch_target),
    .pc_updated     (pc_updated),
    .misalign_err   (misalign_err)
`ifdef PC_BRANCH_STATS_EN
    ,
    .branch_count   (branch_count),
    .taken_count    (taken_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the architectural effect of one clock edge.
  logic [31:0] m_pc, m_bt, m_bc, m_tc;
  logic        m_upd, m_err;

  function automatic logic [31:0] target_of(input logic [1:0] s, input logic [31:0] p,
                                            input logic [31:0] bt, input logic [25:0] ji,
                                            input logic [31:0] rt);
    if (s == 2'd0) return p + 32'd4;
    if (s == 2'd1) return bt;
    if (s == 2'd2) return (p & 32'hF000_0000) | (32'(ji) * 32'd4);
    return rt;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= RST_PC; m_bt <= 0; m_upd <= 0; m_err <= 0; m_bc <= 0; m_tc <= 0;
    end else begin
      logic [31:0] t;
      logic        tk;
      t  = target_of(pc_src, m_pc, m_bt, jump_index, reg_target);
      tk = pc_write || (pc_write_cond && (alu_zero != branch_ne));
      m_upd <= tk && (t % 4 == 0);
      if (tk && (t % 4 == 0)) m_pc <= t;
      if (bt_load) m_bt <= m_pc + offset_shifted;
      if (tk && (t % 4 != 0)) m_err <= 1'b1;
      else if (err_clr)       m_err <= 1'b0;
      if (pc_write_cond && !pc_write) begin
        m_bc <= m_bc + 1;
        if (tk && (t % 4 == 0)) m_tc <= m_tc + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("model_pc", pc, m_pc);
      check("model_bt", branch_target, m_bt);
      check("model_upd", 32'(pc_updated), 32'(m_upd));
      check("model_err", 32'(misalign_err), 32'(m_err));
`ifdef PC_BRANCH_STATS_EN
      check("model_bcnt", branch_count, m_bc);
      check("model_tcnt", taken_count, m_tc);
`endif
    end
  end

  task automatic idle();
    pc_write = 0; pc_write_cond = 0; branch_ne = 0; alu_zero = 0; pc_src = 0;
    bt_load = 0; err_clr = 0; offset_shifted = 0; jump_index = 0; reg_target = 0;
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic load_pc(input logic [31:0] v);
    idle(); pc_write = 1; pc_src = 2'd3; reg_target = v;
    cyc();
    idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_bt", branch_target, 32'h0);
    check("rst_upd", 32'(pc_updated), 32'h0);
    check("rst_err", 32'(misalign_err), 32'h0);
    rst_n = 1'b1;

    // Sequential fetch from the reset PC
    pc_write = 1; pc_src = 2'd0;
    cyc(); check("seq1", pc, 32'h0000_3004); check("seq1_upd", 32'(pc_updated), 1);
    cyc(); check("seq2", pc, 32'h0000_3008); check("seq2_upd", 32'(pc_updated), 1);
    cyc(); check("seq3", pc, 32'h0000_300C); check("seq3_upd", 32'(pc_updated), 1);
    idle(); cyc(); check("seq_idle_upd", 32'(pc_updated), 0);

    // Branch target latch and beq/bne resolve
    load_pc(32'h0000_1000);
    bt_load = 1; offset_shifted = 32'hFFFF_FFF0;
    cyc(); check("bt_latch", branch_target, 32'h0000_0FF0);
    idle(); pc_write_cond = 1; pc_src = 2'd1; alu_zero = 1; branch_ne = 0;
    cyc(); check("beq_taken", pc, 32'h0000_0FF0); check("beq_upd", 32'(pc_updated), 1);
    branch_ne = 1;
    cyc(); check("bne_not", pc, 32'h0000_0FF0); check("bne_upd", 32'(pc_updated), 0);

    // Jump keeps the upper nibble of the PC
    load_pc(32'hA000_0010);
    pc_write = 1; pc_src = 2'd2; jump_index = 26'h0000040;
    cyc(); check("jump", pc, 32'hA000_0100);

    // Misaligned jr traps; clear; set wins over clear
    idle(); pc_write = 1; pc_src = 2'd3; reg_target = 32'h0000_2002;
    cyc(); check("mis_pc", pc, 32'hA000_0100); check("mis_err", 32'(misalign_err), 1);
    check("mis_upd", 32'(pc_updated), 0);
    idle(); err_clr = 1;
    cyc(); check("err_clr", 32'(misalign_err), 0);
    pc_write = 1; pc_src = 2'd3; reg_target = 32'h0000_2001;
    cyc(); check("err_set_wins", 32'(misalign_err), 1);
    idle(); err_clr = 1; cyc(); idle();

    // Wrap past the top of the address space; bt_load uses the old PC
    load_pc(32'hFFFF_FFFC);
    pc_write = 1; pc_src = 2'd0; bt_load = 1; offset_shifted = 32'h0000_0008;
    cyc(); check("wrap_pc", pc, 32'h0000_0000); check("bt_oldpc", branch_target, 32'h0000_0004);

    // Asynchronous reset in the middle of a write sequence
    idle(); pc_write = 1; pc_src = 2'd0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_pc", pc, 32'h0000_3000);
    check("async_upd", 32'(pc_updated), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pc_write = 1; pc_src = 2'd0;
    cyc(); check("post_rst_write", pc, 32'h0000_3004);

`ifdef PC_BRANCH_STATS_EN
    // Four conditional branches, two taken
    idle(); rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc_write_cond = 1; pc_src = 2'd0; alu_zero = (i % 2 == 0); branch_ne = 0;
      cyc();
    end
    idle();
    check("branch_count", branch_count, 32'd4);
    check("taken_count", taken_count, 32'd2);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      pc_write       = ($urandom_range(0, 3) == 0);
      pc_write_cond  = ($urandom_range(0, 2) == 0);
      branch_ne      = 1'($urandom);
      alu_zero       = 1'($urandom);
      pc_src         = 2'($urandom);
      bt_load        = ($urandom_range(0, 3) == 0);
      err_clr        = ($urandom_range(0, 5) == 0);
      offset_shifted = $urandom << 2;
      jump_index     = 26'($urandom);
      reg_target     = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
    end
    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_update_unit.md
# pc_update_unit

Program-counter unit for the multi-cycle CPU, sitting directly downstream of the 2-bit left shifter. It consumes the word-aligned branch offset, latches the branch target during decode, and updates the PC on fetch, branch-resolve or jump cycles under main-controller strobes. Misaligned control transfers are trapped with a sticky error flag, and optional branch statistics counters can be compiled in.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word-aligned)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pc_write  in  1  unconditional PC write strobe
- pc_write_cond  in  1  conditional PC write strobe (branch resolve)
- branch_ne  in  1  0 = beq semantics, 1 = bne semantics
- alu_zero  in  1  ALU zero flag of the compare
- pc_src  in  2  0 = PC+4, 1 = branch target, 2 = jump, 3 = register (jr)
- bt_load  in  1  latch branch target (decode cycle)
- offset_shifted  in  32  sign-extended immediate already shifted left by 2
- jump_index  in  26  instr[25:0]
- reg_target  in  32  rs value for jr
- err_clr  in  1  clears misalign_err
- pc  out  32  current PC
- branch_target  out  32  latched branch target
- pc_updated  out  1  one-cycle pulse, PC changed on the previous edge
- misalign_err  out  1  sticky: a misaligned target was rejected

## Operation
- Candidate next PC:
  - src0: pc+4, mod 2^32
  - src1: branch_target
  - src2: {pc[31:28], jump_index, 2'b00}
  - src3: reg_target
- take = pc_write | (pc_write_cond & (alu_zero ^ branch_ne)).
- pc_write dominates. With pc_write=1, pc_write_cond and the flag are ignored.
- If take and candidate[1:0] != 0: PC is not written, misalign_err <= 1, pc_updated stays 0.
- If take and the candidate is aligned: pc <= candidate, pc_updated <= 1.
- bt_load: branch_target <= pc + offset_shifted, 32-bit wrap with no overflow flag. It uses the PC value before any same-cycle write.
- bt_load together with a PC write in the same cycle: both occur. The target is computed from the old PC.
- err_clr clears misalign_err. If a new misalignment occurs in the same cycle, the set wins.

## Timing
- Reset values: pc = RESET_PC, branch_target = 0, pc_updated = 0, misalign_err = 0, and counters (if present) = 0.
- All state changes happen on the rising edge. There are no combinational paths from inputs to outputs.
- PC write latency is 1 cycle. pc_updated is high for exactly the cycle following the write edge.
- Reset asserted mid-operation restores the reset values immediately. The first write is possible on the first edge after rst_n deasserts.

## Configuration
- PC_BRANCH_STATS_EN defined:
  - Adds outputs branch_count[31:0], incremented on every cycle with pc_write_cond=1 and pc_write=0.
  - Adds outputs taken_count[31:0], incremented when such a branch is taken and aligned.
  - Both counters wrap at 2^32.
- Undefined: the counter ports and logic are absent. All other behaviour is identical.

## Structure
- A shared package holds:
  - PC_SRC_* constants (PC_SRC_SEQ=0, PC_SRC_BR=1, PC_SRC_JMP=2, PC_SRC_REG=3)
  - the word width of 32
  - the RESET_PC default
- One sub-module, pc_next_mux: pure combinational candidate selection and alignment check. Registers, take logic and counters stay in the top module.

## Test plan
- Reset with RESET_PC=32'h0000_3000, release, then pc_write=1, pc_src=0 for 3 cycles -> pc goes 3004, 3008, 300C. pc_updated is high each following cycle.
- pc=0x1000, bt_load with offset_shifted=32'hFFFF_FFF0 -> branch_target=0x0FF0. Then pc_write_cond=1, pc_src=1, alu_zero=1, branch_ne=0 -> pc=0x0FF0. Repeating with branch_ne=1 -> pc unchanged, no pulse.
- pc=0xA000_0010, pc_src=2, jump_index=26'h0000040 -> pc=0xA000_0100.
- pc_src=3, reg_target=0x0000_2002, pc_write=1 -> pc unchanged and misalign_err=1. err_clr -> misalign_err=0 on the next cycle.
- pc=0xFFFF_FFFC, pc_src=0, pc_write -> pc=0x0000_0000. Assert rst_n low mid-sequence -> pc returns to RESET_PC asynchronously.
- PC_BRANCH_STATS_EN: 4 conditional branches, 2 taken -> branch_count=4, taken_count=2.
